// File: rtl/tick_pkg.sv
// Shared definitions for the clock/reset sequencer: FSM state encoding and the
// default divider constants so the core and its bench agree on strobe rates.
package tick_pkg;

  // One-hot so core_reset/running decode straight from a single flopped bit.
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'b001,
    HOLD      = 3'b010,
    RUN       = 3'b100
  } seq_state_e;

  localparam int unsigned RUN_BIT         = 2;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned HOLD_CYCLES_DEF = 1024;
  localparam int unsigned CPU_DIV_DEF     = 14;
  localparam int unsigned VDP_DIV_DEF     = 4;
  localparam int unsigned PSG_DIV_DEF     = 16;

  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/clk_reset_sequencer_ce_divider.sv
// Modulo-DIV tick counter producing a registered one-cycle enable strobe on the
// cycle after its terminal count; wrap exposes the terminal tick for chaining.
module ce_divider
  import tick_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic tick_in,
  output logic ce,
  output logic wrap
);

  localparam int unsigned     CW   = cnt_width(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign wrap = tick_in && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick_in) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ce    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce    <= wrap && !clr;
    end
  end

endmodule

// File: rtl/clk_reset_sequencer.sv
// PLL-lock synchroniser, core reset sequencing and CPU/VDP/PSG clock-enable
// generation, all on the single PLL output clock.
module clk_reset_sequencer
  import tick_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned CPU_DIV     = CPU_DIV_DEF,
  parameter int unsigned VDP_DIV     = VDP_DIV_DEF,
  parameter int unsigned PSG_DIV     = PSG_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic soft_reset,
  output logic core_reset,
  output logic ce_cpu,
  output logic ce_vdp,
  output logic ce_psg,
  output logic running
);

  localparam int unsigned   HW        = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  seq_state_e             state_q;
  logic [HW-1:0]          hold_cnt_q;
  logic                   run_next;
  logic                   div_clr;
  logic                   cpu_wrap;
  logic                   vdp_wrap_unused;
  logic                   psg_wrap_unused;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Lock loss outranks soft_reset everywhere; soft_reset in HOLD restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_LOCK;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (locked_s) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
          end
        end
        HOLD: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
          end else if (soft_reset) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q <= RUN;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
          end else if (soft_reset) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= WAIT_LOCK;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign running    = state_q[RUN_BIT];
  assign core_reset = ~state_q[RUN_BIT];

  // Clearing on the exit edge too keeps a strobe from landing on the first reset cycle.
  assign run_next = locked_s && !soft_reset &&
                    (state_q[RUN_BIT] || ((state_q == HOLD) && (hold_cnt_q == HOLD_LAST)));
  assign div_clr  = !running || !run_next;

  ce_divider #(.DIV(CPU_DIV)) u_cpu_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (div_clr),
    .tick_in (1'b1),
    .ce      (ce_cpu),
    .wrap    (cpu_wrap)
  );

  ce_divider #(.DIV(VDP_DIV)) u_vdp_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (div_clr),
    .tick_in (1'b1),
    .ce      (ce_vdp),
    .wrap    (vdp_wrap_unused)
  );

  // PSG counts CPU terminal ticks, so its strobe lands on the same edge as ce_cpu.
  ce_divider #(.DIV(PSG_DIV)) u_psg_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (div_clr),
    .tick_in (cpu_wrap),
    .ce      (ce_psg),
    .wrap    (psg_wrap_unused)
  );

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Bench for clk_reset_sequencer: directed scenarios plus randomized lock/soft
// reset events, every cycle compared against a timestamp-based reference model.
module tb_clk_reset_sequencer;
  import tick_pkg::*;

  localparam int SYNC   = SYNC_STAGES_DEF;
  localparam int HOLD_N = HOLD_CYCLES_DEF;
  localparam int CPU_D  = CPU_DIV_DEF;
  localparam int VDP_D  = VDP_DIV_DEF;
  localparam int PSG_D  = PSG_DIV_DEF;
  localparam int LOCK_TO_RUN = SYNC + 1 + HOLD_N;

  logic clk = 1'b0;
  logic reset_n, pll_locked, soft_reset;
  logic core_reset, ce_cpu, ce_vdp, ce_psg, running;

  always #5 clk = ~clk;

  clk_reset_sequencer #(
    .SYNC_STAGES (SYNC),
    .HOLD_CYCLES (HOLD_N),
    .CPU_DIV     (CPU_D),
    .VDP_DIV     (VDP_D),
    .PSG_DIV     (PSG_D)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .soft_reset (soft_reset),
    .core_reset (core_reset),
    .ce_cpu     (ce_cpu),
    .ce_vdp     (ce_vdp),
    .ce_psg     (ce_psg),
    .running    (running)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase plus timestamps of the last hold start / run start.
  int m_cyc, m_mode, m_hold_start, m_run_start;
  bit lk_hist[$];

  function automatic void model_reset();
    m_cyc = 0;
    m_mode = 0;
    m_hold_start = 0;
    m_run_start = 0;
    lk_hist.delete();
  endfunction

  function automatic void model_step();
    bit ls;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_cyc++;
    ls = (lk_hist.size() >= SYNC) ? lk_hist[SYNC-1] : 1'b0;
    case (m_mode)
      0: if (ls) begin m_mode = 1; m_hold_start = m_cyc; end
      1: begin
        if (!ls) m_mode = 0;
        else if (soft_reset) m_hold_start = m_cyc;
        else if (m_cyc - m_hold_start == HOLD_N) begin m_mode = 2; m_run_start = m_cyc; end
      end
      default: begin
        if (!ls) m_mode = 0;
        else if (soft_reset) begin m_mode = 1; m_hold_start = m_cyc; end
      end
    endcase
    lk_hist.push_front(pll_locked);
    if (lk_hist.size() > SYNC) void'(lk_hist.pop_back());
  endfunction

  function automatic logic [4:0] model_out();
    int t;
    logic run;
    run = (m_mode == 2);
    t = m_cyc - m_run_start;
    return {!run, run,
            run && t > 0 && (t % CPU_D) == 0,
            run && t > 0 && (t % VDP_D) == 0,
            run && t > 0 && (t % (CPU_D * PSG_D)) == 0};
  endfunction

  function automatic logic [4:0] dut_out();
    return {core_reset, running, ce_cpu, ce_vdp, ce_psg};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic measure_fall(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (core_reset && n < 3000);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check(tag, 32'(dut_out()), 32'(5'b10000));
    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, hi, first_cpu, cpu_n, vdp_n, psg_n, dbl, misalign;
    logic prev_cpu, prev_vdp;

    reset_n = 1'b0;
    pll_locked = 1'b1;
    soft_reset = 1'b0;
    model_reset();
    #1 check("reset_state", 32'(dut_out()), 32'(5'b10000));
    repeat (3) tick();

    // Lock present at release: fall after SYNC+1+HOLD cycles.
    reset_n = 1'b1;
    measure_fall(n);
    check("lock_to_run", n, LOCK_TO_RUN);
    check("running_at_fall", 32'(running), 32'(1'b1));

    // Strobe rates and alignment from the start of RUN.
    first_cpu = -1; cpu_n = 0; vdp_n = 0; psg_n = 0; dbl = 0; misalign = 0;
    prev_cpu = 1'b0; prev_vdp = 1'b0;
    for (int i = 1; i <= CPU_D * PSG_D * 3; i++) begin
      tick();
      if (ce_cpu && first_cpu < 0) first_cpu = i;
      if (i <= 140) begin
        cpu_n += int'(ce_cpu);
        vdp_n += int'(ce_vdp);
      end
      if ((ce_cpu && prev_cpu) || (ce_vdp && prev_vdp)) dbl++;
      psg_n += int'(ce_psg);
      if (ce_psg && !ce_cpu) misalign++;
      prev_cpu = ce_cpu;
      prev_vdp = ce_vdp;
    end
    check("cpu_in_140", cpu_n, 10);
    check("vdp_in_140", vdp_n, 35);
    check("first_cpu", first_cpu, CPU_D);
    check("pulse_width", dbl, 0);
    check("psg_count", psg_n, 3);
    check("psg_align", misalign, 0);

    // One-cycle lock drop in RUN, then relock.
    pll_locked = 1'b0;
    tick();
    n = 1;
    pll_locked = 1'b1;
    while (!core_reset && n < 10) begin
      tick();
      n++;
    end
    check("loss_latency", n, SYNC + 1);
    check("loss_strobes", 32'({ce_cpu, ce_vdp, ce_psg}), 32'(3'b000));
    measure_fall(m);
    check("relock_to_run", n - 1 + m, LOCK_TO_RUN);

    // soft_reset in RUN: hold only, no lock wait.
    repeat (20) tick();
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    hi = int'(core_reset);
    n = 0;
    while (core_reset && n < 3000) begin
      tick();
      hi += int'(core_reset);
      n++;
    end
    check("soft_hold_len", hi, HOLD_N);

    // soft_reset coincident with synchronised lock loss: lock loss wins.
    repeat (30) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check("soft_vs_loss_reset", 32'(core_reset), 32'(1'b1));
    measure_fall(m);
    check("soft_loss_relock", 2 + m, LOCK_TO_RUN);

    // Asynchronous reset mid-HOLD and mid-RUN.
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    repeat (300) tick();
    async_reset("async_rst_hold");
    measure_fall(n);
    check("post_hold_rst_run", n, LOCK_TO_RUN);
    repeat (CPU_D - 1) tick();
    async_reset("async_rst_run");
    measure_fall(n);
    check("post_run_rst_run", n, LOCK_TO_RUN);
    first_cpu = -1;
    for (int i = 1; i <= CPU_D + 4; i++) begin
      tick();
      if (ce_cpu && first_cpu < 0) first_cpu = i;
    end
    check("post_rst_first_cpu", first_cpu, CPU_D);

    // Randomized lock drops, soft resets (any state) and resets.
    for (int it = 0; it < 10; it++) begin
      int kind, len;
      kind = $urandom_range(0, 4);
      len = $urandom_range(1, 6);
      case (kind)
        0: begin soft_reset = 1'b1; repeat (len) tick(); soft_reset = 1'b0; end
        1: begin pll_locked = 1'b0; repeat (len) tick(); pll_locked = 1'b1; end
        2: begin
          pll_locked = 1'b0;
          soft_reset = 1'b1;
          repeat (len) tick();
          soft_reset = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
          pll_locked = 1'b1;
        end
        3: async_reset("async_rst_rand");
        default: ;
      endcase
      repeat ($urandom_range(1, 1200)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
